// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: default geometry, window type and
// the row-pairing state used by the pooling front end.
package cnn_pkg;

  localparam int CNN_DATA_WIDTH = 8;
  localparam int CNN_POOL_UNITS = 32;

  // One 2x2 pooling window, elements 0..3 = top-left, top-right, bottom-left, bottom-right
  typedef logic [3:0][CNN_DATA_WIDTH-1:0] window_t;

  typedef enum logic {
    ROW_EVEN = 1'b0,
    ROW_ODD  = 1'b1
  } row_state_e;

  typedef enum logic [1:0] {
    POOL_MAX = 2'd0,
    POOL_AVG = 2'd1,
    POOL_MIN = 2'd2
  } pool_mode_e;

  typedef struct packed {
    logic valid;
    logic last;
  } pool_ctrl_t;

endpackage

// File: rtl/pool_window_buffer.sv
// Pairs consecutive image rows and emits POOL_UNITS 2x2 windows per beat
// to the pooling stage, with a one-deep registered output stage.
module pool_window_buffer
  import cnn_pkg::*;
#(
  parameter int POOL_UNITS = CNN_POOL_UNITS,
  parameter int DATA_WIDTH = CNN_DATA_WIDTH
) (
  input  logic                                       clk,
  input  logic                                       nrst,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [2*POOL_UNITS-1:0][DATA_WIDTH-1:0]    in_data,
  input  logic                                       in_last,
  output logic                                       win_valid,
  input  logic                                       win_ready,
  output logic [POOL_UNITS-1:0][3:0][DATA_WIDTH-1:0] win_data,
  output logic                                       frame_done,
  output logic                                       err_odd_rows
);

  row_state_e                                 r_state;
  logic [2*POOL_UNITS-1:0][DATA_WIDTH-1:0]    r_row;
  logic [POOL_UNITS-1:0][3:0][DATA_WIDTH-1:0] r_win;
  logic                                       r_win_valid;
  logic                                       r_win_last;
  logic                                       r_err;

  logic                                       w_in_ready;
  logic                                       w_in_fire;
  logic                                       w_out_fire;
  logic                                       w_even_fire;
  logic                                       w_pair_fire;
  logic [POOL_UNITS-1:0][3:0][DATA_WIDTH-1:0] w_win_next;

  // The odd row may enter while the output register drains in the same cycle
  assign w_in_ready  = (r_state == ROW_EVEN) || !r_win_valid || win_ready;
  assign w_in_fire   = in_valid && w_in_ready;
  assign w_out_fire  = r_win_valid && win_ready;
  assign w_even_fire = w_in_fire && (r_state == ROW_EVEN);
  assign w_pair_fire = w_in_fire && (r_state == ROW_ODD);

  for (genvar gi = 0; gi < POOL_UNITS; gi++) begin : g_win
    assign w_win_next[gi][0] = r_row[2*gi];
    assign w_win_next[gi][1] = r_row[2*gi+1];
    assign w_win_next[gi][2] = in_data[2*gi];
    assign w_win_next[gi][3] = in_data[2*gi+1];
  end

  // A last-flagged even row has no partner: drop it and flag the frame
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ROW_EVEN;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ROW_EVEN: begin
          if (w_in_fire) begin
            if (in_last) begin
              r_err <= 1'b1;
            end else begin
              r_state <= ROW_ODD;
            end
          end
        end
        ROW_ODD: begin
          if (w_in_fire) begin
            r_state <= ROW_EVEN;
          end
        end
        default: r_state <= ROW_EVEN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_row <= '0;
    end else if (w_even_fire && !in_last) begin
      r_row <= in_data;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_win       <= '0;
      r_win_valid <= 1'b0;
      r_win_last  <= 1'b0;
    end else if (w_pair_fire) begin
      r_win       <= w_win_next;
      r_win_valid <= 1'b1;
      r_win_last  <= in_last;
    end else if (w_out_fire) begin
      r_win_valid <= 1'b0;
    end
  end

  assign in_ready     = w_in_ready;
  assign win_valid    = r_win_valid;
  assign win_data     = r_win;
  assign frame_done   = w_out_fire && r_win_last;
  assign err_odd_rows = r_err;

endmodule
